// File: rtl/cplx_alu_driver_if.sv
// Bundle of the request, response and ALU-side signals of the complex ALU driver.
// master: host sequencer plus ALU; slave: the driver itself.
interface cplx_alu_driver_if #(
  parameter int CNT_W = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [3:0]          req_a;
  logic [3:0]          req_b;
  logic [3:0]          req_c;
  logic [3:0]          req_d;

  logic [17:0]         alu_data;
  logic                alu_load;
  logic signed [7:0]   alu_result_r;
  logic signed [7:0]   alu_result_i;

  logic                resp_valid;
  logic                resp_ready;
  logic signed [7:0]   resp_r;
  logic signed [7:0]   resp_i;
  logic                resp_err;
  logic [CNT_W-1:0]    cmd_count;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, req_d,
    output resp_ready, alu_result_r, alu_result_i,
    input  req_ready, alu_data, alu_load,
    input  resp_valid, resp_r, resp_i, resp_err, cmd_count
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, req_d,
    input  resp_ready, alu_result_r, alu_result_i,
    output req_ready, alu_data, alu_load,
    output resp_valid, resp_r, resp_i, resp_err, cmd_count
  );
endinterface

// File: rtl/cplx_alu_driver.sv
// Single-command initiator for the complex ALU: packs a request into the instruction
// word, strobes load, waits the opcode latency, captures the result and returns it.
module cplx_alu_driver #(
  parameter int LAT_ADD = 6,
  parameter int LAT_SUB = 6,
  parameter int LAT_MUL = 10,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cplx_alu_driver_if.slave bus
);

  localparam int LAT_AS  = (LAT_ADD > LAT_SUB) ? LAT_ADD : LAT_SUB;
  localparam int LAT_MAX = (LAT_AS > LAT_MUL) ? LAT_AS : LAT_MUL;
  localparam int WAIT_W  = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                accept;
  logic                handshake;
  logic                op_illegal;

  // Counter preload is LAT-1 so that WAIT lasts LAT cycles and CAPTURE lands LAT+1 after LOAD.
  function automatic logic [WAIT_W-1:0] wait_init(input logic [1:0] op);
    case (op)
      2'b00:   return WAIT_W'(LAT_ADD - 1);
      2'b01:   return WAIT_W'(LAT_SUB - 1);
      default: return WAIT_W'(LAT_MUL - 1);
    endcase
  endfunction

  assign accept     = bus.req_valid && bus.req_ready;
  assign handshake  = bus.resp_valid && bus.resp_ready;
  assign op_illegal = (bus.req_op == 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = op_illegal ? S_RESP : S_LOAD;
        end
      end
      S_LOAD:    state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP: begin
        if (handshake) begin
          state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.alu_load   = (state == S_LOAD);
    bus.resp_valid = (state == S_RESP);
  end

  // alu_data is only rewritten on acceptance, so the ALU sees a stable word at every load edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.alu_data  <= '0;
      wait_cnt      <= '0;
      bus.resp_r    <= '0;
      bus.resp_i    <= '0;
      bus.resp_err  <= 1'b0;
      bus.cmd_count <= '0;
    end else begin
      if (accept) begin
        bus.alu_data <= {bus.req_op, bus.req_a, bus.req_b, bus.req_c, bus.req_d};
        wait_cnt     <= wait_init(bus.req_op);
        if (op_illegal) begin
          bus.resp_r   <= '0;
          bus.resp_i   <= '0;
          bus.resp_err <= 1'b1;
        end
      end
      if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (state == S_CAPTURE) begin
        bus.resp_r   <= bus.alu_result_r;
        bus.resp_i   <= bus.alu_result_i;
        bus.resp_err <= 1'b0;
      end
      if (handshake) begin
        bus.cmd_count <= bus.cmd_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cplx_alu_driver.sv
// Scoreboard bench for cplx_alu_driver with a behavioural ALU that presents its
// result only during the cycle the driver is expected to capture it.
module tb_cplx_alu_driver;
  localparam int LAT_ADD = 6;
  localparam int LAT_SUB = 6;
  localparam int LAT_MUL = 10;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cplx_alu_driver_if #(.CNT_W(CNT_W)) ifc();

  cplx_alu_driver #(
    .LAT_ADD(LAT_ADD), .LAT_SUB(LAT_SUB), .LAT_MUL(LAT_MUL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  typedef struct {
    logic [7:0] r;
    logic [7:0] i;
    logic       err;
    logic [7:0] cnt;
    int         lat;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_h;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         accept_cyc = -1;
  int         loads_at_accept = 0;
  int         n_loads = 0;
  int         last_load = -1;
  int         last_lat = 0;
  logic [7:0] exp_count = 8'd0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_r = 8'd0;
  logic [7:0] prev_i = 8'd0;
  logic       prev_err = 1'b0;
  logic       cnt_pending = 1'b0;
  logic [7:0] cnt_exp = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: result valid only in cycle LAT+1 after the load cycle, junk otherwise.
  int alu_cnt = 0;
  int alu_lat = 0;
  int sa, sb, sc, sd, mr, mi;
  logic signed [7:0] alu_pr = 8'sd0;
  logic signed [7:0] alu_pi = 8'sd0;

  always_comb begin
    sa = int'($signed(ifc.alu_data[15:12]));
    sb = int'($signed(ifc.alu_data[11:8]));
    sc = int'($signed(ifc.alu_data[7:4]));
    sd = int'($signed(ifc.alu_data[3:0]));
    mr = 0;
    mi = 0;
    case (ifc.alu_data[17:16])
      2'b00:   begin mr = sa + sc; mi = sb + sd; end
      2'b01:   begin mr = sa - sc; mi = sb - sd; end
      default: begin mr = sa * sc - sb * sd; mi = sa * sd + sb * sc; end
    endcase
  end

  always @(posedge clk) begin
    if (ifc.alu_load) begin
      alu_cnt <= 1;
      alu_pr  <= 8'(mr);
      alu_pi  <= 8'(mi);
      alu_lat <= (ifc.alu_data[17:16] == 2'b10) ? LAT_MUL :
                 (ifc.alu_data[17:16] == 2'b01) ? LAT_SUB : LAT_ADD;
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt + 1;
    end
  end

  assign ifc.alu_result_r = (alu_cnt == alu_lat + 1) ? alu_pr : 8'sh7F;
  assign ifc.alu_result_i = (alu_cnt == alu_lat + 1) ? alu_pi : 8'sh7F;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready",  32'(ifc.req_ready), 32'd1);
    chk("rst_alu_load",   32'(ifc.alu_load), 32'd0);
    chk("rst_alu_data",   32'(ifc.alu_data), 32'd0);
    chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("rst_resp_r",     32'($unsigned(ifc.resp_r)), 32'd0);
    chk("rst_resp_i",     32'($unsigned(ifc.resp_i)), 32'd0);
    chk("rst_resp_err",   32'(ifc.resp_err), 32'd0);
    chk("rst_cmd_count",  32'(ifc.cmd_count), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    sbq.delete();
    exp_count = 8'd0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input logic [17:0] exp_data,
                       input logic [7:0] er, input logic [7:0] ei, input logic eerr, input int lat);
    exp_t e;
    int   n = 0;
    while (!ifc.req_ready && n < 200) begin
      step();
      n++;
    end
    chk("req_ready_wait", 32'(n < 200), 32'd1);
    exp_count = exp_count + 8'd1;
    e.r = er; e.i = ei; e.err = eerr; e.cnt = exp_count; e.lat = lat;
    sbq.push_back(e);
    ifc.req_valid = 1'b1;
    ifc.req_op = op; ifc.req_a = a; ifc.req_b = b; ifc.req_c = c; ifc.req_d = d;
    accept_cyc = cyc;
    loads_at_accept = n_loads;
    step();
    ifc.req_valid = 1'b0;
    chk("alu_data", 32'(ifc.alu_data), 32'(exp_data));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !ifc.req_ready) && n < 500) begin
      step();
      n++;
    end
    chk("idle_wait", 32'(n < 500), 32'd1);
  endtask

  // Monitor: load spacing, response latency, hold stability and scoreboard compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_load = -1;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        cnt_pending = 1'b0;
      end else begin
        if (cnt_pending) begin
          chk("cmd_count", 32'(ifc.cmd_count), 32'(cnt_exp));
          cnt_pending = 1'b0;
        end
        if (ifc.alu_load) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL load_unexpected: alu_load=1 with nothing outstanding at cycle %0d", cyc);
          end else begin
            if (last_load >= 0) chk("load_spacing_ok", 32'((cyc - last_load) >= last_lat + 3), 32'd1);
            last_lat = sbq[0].lat;
          end
          n_loads++;
          last_load = cyc;
        end
        if (ifc.resp_valid) begin
          chk("req_ready_in_resp", 32'(ifc.req_ready), 32'd0);
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: resp_valid=1 with nothing outstanding at cycle %0d", cyc);
          end else begin
            mon_h = sbq[0];
            if (!prev_valid) begin
              if (mon_h.lat >= 0) begin
                chk("resp_latency", 32'(cyc - last_load), 32'(mon_h.lat + 2));
                chk("loads_per_cmd", 32'(n_loads - loads_at_accept), 32'd1);
                chk("load_after_accept", 32'(last_load), 32'(accept_cyc + 1));
              end else begin
                chk("err_resp_latency", 32'(cyc - accept_cyc), 32'd1);
                chk("err_no_load", 32'(n_loads - loads_at_accept), 32'd0);
              end
            end else if (!prev_ready) begin
              chk("hold_r", 32'($unsigned(ifc.resp_r)), 32'(prev_r));
              chk("hold_i", 32'($unsigned(ifc.resp_i)), 32'(prev_i));
              chk("hold_err", 32'(ifc.resp_err), 32'(prev_err));
            end
            if (ifc.resp_ready) begin
              void'(sbq.pop_front());
              chk("resp_r", 32'($unsigned(ifc.resp_r)), 32'(mon_h.r));
              chk("resp_i", 32'($unsigned(ifc.resp_i)), 32'(mon_h.i));
              chk("resp_err", 32'(ifc.resp_err), 32'(mon_h.err));
              cnt_exp = mon_h.cnt;
              cnt_pending = 1'b1;
            end
          end
        end
        prev_valid = ifc.resp_valid;
        prev_ready = ifc.resp_ready;
        prev_r = $unsigned(ifc.resp_r);
        prev_i = $unsigned(ifc.resp_i);
        prev_err = ifc.resp_err;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [3:0] a, b, c, d;
    ifc.req_valid = 1'b0;
    ifc.req_op = 2'b00;
    ifc.req_a = 4'd0; ifc.req_b = 4'd0; ifc.req_c = 4'd0; ifc.req_d = 4'd0;
    ifc.resp_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    // Add
    issue(2'b00, 4'd3, 4'd2, 4'd1, 4'd4, 18'h03214, 8'd4, 8'd6, 1'b0, LAT_ADD);
    wait_idle();

    // Mul with the response held off for 5 cycles
    ifc.resp_ready = 1'b0;
    issue(2'b10, 4'd2, 4'd3, 4'd4, 4'd1, 18'h22341, 8'd5, 8'd14, 1'b0, LAT_MUL);
    n = 0;
    while (!ifc.resp_valid && n < 100) begin
      step();
      n++;
    end
    chk("mul_resp_wait", 32'(n < 100), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("mul_hold_valid", 32'(ifc.resp_valid), 32'd1);
      step();
    end
    ifc.resp_ready = 1'b1;
    wait_idle();

    // Illegal opcode
    issue(2'b11, 4'hF, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 8'd0, 8'd0, 1'b1, -1);
    wait_idle();

    // Sub with negative result; req_ready low until the response handshake
    issue(2'b01, 4'd1, 4'd0, 4'd5, 4'd2, 18'h11052, 8'hFC, 8'hFE, 1'b0, LAT_SUB);
    n = 0;
    while (!(ifc.resp_valid && ifc.resp_ready) && n < 100) begin
      chk("sub_req_ready_busy", 32'(ifc.req_ready), 32'd0);
      step();
      n++;
    end
    chk("sub_resp_wait", 32'(n < 100), 32'd1);
    step();
    chk("sub_req_ready_after", 32'(ifc.req_ready), 32'd1);
    wait_idle();

    // Reset in the middle of a mul wait
    issue(2'b10, 4'd2, 4'd3, 4'd4, 4'd1, 18'h22341, 8'd5, 8'd14, 1'b0, LAT_MUL);
    for (int k = 0; k < 4; k++) step();
    pulse_reset();
    for (int k = 0; k < LAT_MUL + 6; k++) begin
      chk("abort_no_resp", 32'(ifc.resp_valid), 32'd0);
      step();
    end
    issue(2'b00, 4'd3, 4'd2, 4'd1, 4'd4, 18'h03214, 8'd4, 8'd6, 1'b0, LAT_ADD);
    wait_idle();
    step();
    chk("abort_next_count", 32'(ifc.cmd_count), 32'd1);

    // 256 back-to-back adds wrap the counter
    pulse_reset();
    step();
    for (int k = 0; k < 256; k++) begin
      a = 4'(k % 8);
      b = 4'((k / 8) % 8);
      c = 4'((k * 3) % 8);
      d = 4'((k * 5) % 8);
      issue(2'b00, a, b, c, d, {2'b00, a, b, c, d},
            8'(32'(a) + 32'(c)), 8'(32'(b) + 32'(d)), 1'b0, LAT_ADD);
    end
    wait_idle();
    step();
    chk("wrap_cmd_count", 32'(ifc.cmd_count), 32'd0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cplx_alu_driver.md
Name: cplx_alu_driver

Overview:
- Command-issuing initiator for the complex ALU: accepts complex-operand requests over a valid/ready handshake and packs them into the 18-bit instruction word.
- Pulses load, waits a per-opcode latency, then captures the ALU's result_r/result_i.
- Returns the captured results over a valid/ready response channel.
- Sits between a host/testbench sequencer and the ALU; it is the only block that drives the ALU's data_in and load.

Parameters:
- LAT_ADD, 6, cycles from load pulse to capture for opcode 00 (add)
- LAT_SUB, 6, cycles from load pulse to capture for opcode 01 (sub)
- LAT_MUL, 10, cycles from load pulse to capture for opcode 10 (mul)
- CNT_W, 8, width of the completed-command counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  driver can accept a request
- req_op  in  2  00 add, 01 sub, 10 mul, 11 illegal
- req_a  in  4  real part of operand X
- req_b  in  4  imaginary part of operand X
- req_c  in  4  real part of operand Y
- req_d  in  4  imaginary part of operand Y
- alu_data  out  18  {op[17:16], a[15:12], b[11:8], c[7:4], d[3:0]} to ALU data_in
- alu_load  out  1  one-cycle load strobe to ALU
- alu_result_r  in  8  signed real result from ALU
- alu_result_i  in  8  signed imaginary result from ALU
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_r  out  8  signed captured real result
- resp_i  out  8  signed captured imaginary result
- resp_err  out  1  request carried illegal opcode
- cmd_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (rst_n=0 at posedge):
  - state IDLE; req_ready=1; alu_load=0; alu_data=0.
  - resp_valid=0; resp_r=0; resp_i=0; resp_err=0; cmd_count=0; wait counter=0.
  - Reset mid-operation abandons the command; no response is produced.
- FSM states IDLE, LOAD, WAIT, CAPTURE, RESP.
- IDLE:
  - req_ready=1; accept when req_valid && req_ready at posedge.
  - Register alu_data = {req_op, req_a, req_b, req_c, req_d}.
  - req_op 11: go directly to RESP with resp_err=1, resp_r=0, resp_i=0; no load pulse; alu_data is still updated.
  - Otherwise: go to LOAD and load the wait counter with LAT_x-1 for the opcode.
- LOAD: alu_load=1 for exactly this one cycle; next state WAIT.
- WAIT:
  - Decrement the counter each cycle; at 0, go to CAPTURE.
  - Total cycles from the alu_load-high cycle to the CAPTURE cycle = LAT_x+1.
- CAPTURE: sample alu_result_r/alu_result_i into resp_r/resp_i; resp_err=0; next state RESP.
- RESP:
  - resp_valid=1; resp_r/resp_i/resp_err held stable until the handshake.
  - On resp_valid && resp_ready: cmd_count+1 (wraps 2^CNT_W-1 -> 0), resp_valid drops the next cycle, return to IDLE.
  - resp_r/resp_i/resp_err retain their values after the handshake until the next CAPTURE or error.
- req_ready=0 in every state except IDLE; at most one command is in flight.
- alu_data is held constant from acceptance until the next acceptance, because the ALU samples it on load edges.
- A new request can be accepted the cycle after a response handshake, not the same cycle.
- alu_load is never high outside LOAD. Back-to-back commands produce load pulses at least LAT_x+3 cycles apart.
- No arithmetic inside the driver; result widths pass through unchanged, signed.

Test Plan:
- Add: req op=00, a=3, b=2, c=1, d=4 -> alu_data=0x03214; single load pulse; capture 6+1 cycles later; resp_r=4, resp_i=6, resp_err=0; cmd_count=1.
- Mul: op=10, a=2, b=3, c=4, d=1 -> alu_data=0x22341; capture after LAT_MUL; resp_r=5, resp_i=14; the response is held while resp_ready is kept low for 5 cycles, then completes.
- Illegal op=11, a=b=c=d=0xF -> no alu_load; resp_valid the cycle after accept; resp_err=1, resp_r=0, resp_i=0; cmd_count increments.
- Sub with a negative result: op=01, a=1, b=0, c=5, d=2, ALU model returns -4/-2 -> resp_r=0xFC, resp_i=0xFE; req_ready stays 0 until the response handshake.
- Reset mid-WAIT: assert rst_n=0 for one cycle during a mul -> all outputs at reset values; no resp_valid; the next add completes normally with cmd_count=1.
- Wrap: issue 256 add commands back-to-back with resp_ready=1 -> cmd_count returns to 0; load pulses are never closer than LAT_ADD+3 cycles.
